// File: rtl/loader_pkg.sv
// loader_pkg: state encoding and framing constants shared by the image loader.
// Optional macro LOADER_CHECKSUM_EN adds the CSUM state to the state enum.
package loader_pkg;

    // Each header field and each payload word is this many bytes.
    localparam int HDR_BYTES  = 4;
    localparam int BYTE_CNT_W = $clog2(HDR_BYTES);
    localparam int CSUM_W     = 32;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        HDR_ADDR,
        HDR_LEN,
        PAYLOAD,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        HDR_ADDR,
        HDR_LEN,
        PAYLOAD,
        WRITE,
        DONE,
        ERROR
    } state_t;
`endif

endpackage

// File: rtl/be_word_assembler.sv
// be_word_assembler: packs accepted bytes into big-endian 32-bit words.
// Ports: clk, clear (sync), valid/data (accepted byte), word/word_valid (pulse).
module be_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [BYTE_CNT_W-1:0] LAST = BYTE_CNT_W'(HDR_BYTES - 1);

    logic [23:0]           shift_q;
    logic [BYTE_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (valid) begin
            shift_q <= {shift_q[15:0], data};
            cnt_q   <= cnt_q + BYTE_CNT_W'(1);
        end
    end

    // The word is complete in the same cycle its last byte is accepted,
    // so the consumer captures it on that edge.
    assign word       = {shift_q, data};
    assign word_valid = valid & (cnt_q == LAST);

endmodule

// File: rtl/mem_image_loader.sv
// mem_image_loader: parses a byte-stream image (base, count, words) and
// writes it into CPU memory, holding the CPU in reset until it completes.
// Ports: clk, reset (sync, active high); in_valid/in_data/in_ready byte
// stream; mem_wr_* word-write port; cpu_reset_hold, done, error flags.
// Optional macro LOADER_CHECKSUM_EN: trailing 32-bit payload sum check.
module mem_image_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              cpu_reset_hold,
    output logic              done,
    output logic              error
);

    localparam logic [32:0] ADDR_LIMIT = 33'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t LOAD_END = CSUM;
`else
    localparam state_t LOAD_END = DONE;
`endif

    state_t state_q, state_d;

    logic [31:0]       base_q;
    logic [31:0]       rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q;
`endif

    logic        accept;
    logic [31:0] word;
    logic        word_valid;
    logic [32:0] span;
    logic        hdr_bad;

    assign accept = in_valid & in_ready;

    be_word_assembler u_asm (
        .clk        (clk),
        .clear      (reset),
        .valid      (accept),
        .data       (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Evaluated when the count word completes; word holds N then.
    // 33 bits so a huge N cannot wrap past the limit.
    assign span    = {3'b000, base_q[31:2]} + {1'b0, word};
    assign hdr_bad = (base_q[1:0] != 2'b00) | (span > ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HDR_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        mem_wr_valid   = 1'b0;
        cpu_reset_hold = 1'b1;
        done           = 1'b0;
        error          = 1'b0;
        unique case (state_q)
            HDR_ADDR: begin
                in_ready = ~reset;
                if (word_valid) state_d = HDR_LEN;
            end
            HDR_LEN: begin
                in_ready = ~reset;
                if (word_valid) begin
                    if (hdr_bad)          state_d = ERROR;
                    else if (word == '0)  state_d = LOAD_END;
                    else                  state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                in_ready = ~reset;
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                mem_wr_valid = 1'b1;
                if (mem_wr_ready) begin
                    state_d = (rem_q == 32'd1) ? LOAD_END : PAYLOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = ~reset;
                if (word_valid) begin
                    state_d = (word == csum_q) ? DONE : ERROR;
                end
            end
`endif
            DONE: begin
                done           = 1'b1;
                cpu_reset_hold = 1'b0;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: state_d = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            rem_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            if (state_q == HDR_ADDR && word_valid) begin
                base_q <= word;
            end
            if (state_q == HDR_LEN && word_valid) begin
                rem_q  <= word;
                addr_q <= base_q[ADDR_W+1:2];
            end
            if (state_q == PAYLOAD && word_valid) begin
                data_q <= word;
`ifdef LOADER_CHECKSUM_EN
                csum_q <= csum_q + word;
`endif
            end
            if (state_q == WRITE && mem_wr_ready) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - 32'd1;
            end
        end
    end

    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader: directed image streams checked against an image-level
// model of expected memory writes and final done/error outcome.
`timescale 1ns/1ps
module tb_mem_image_loader;

    localparam int ADDR_W = 18;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_wr_valid;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_wr_ready = 1'b1;
    logic              cpu_reset_hold;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    mem_image_loader #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_ready   (mem_wr_ready),
        .cpu_reset_hold (cpu_reset_hold),
        .done           (done),
        .error          (error)
    );

    int  vectors = 0;
    int  miscompares = 0;
    wr_t exp_q[$];
    bit  exp_done;
    bit  exp_err;
    int  stall_left = 0;
    int  n_writes = 0;
    bit  have_prev = 1'b0;
    logic [31:0] prev_a;
    logic [31:0] prev_d;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Image-level model: what memory must receive and how the load ends.
    task automatic model(input bq_t b);
        longint unsigned base, n, lim, sum, c;
        logic [31:0] w;
        int k;
        base = 64'({b[0], b[1], b[2], b[3]});
        n    = 64'({b[4], b[5], b[6], b[7]});
        lim  = 64'd1 << ADDR_W;
        exp_q.delete();
        if ((base % 4) != 0 || (base / 4 + n) > lim) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        sum = 0;
        for (longint unsigned i = 0; i < n; i++) begin
            k = 8 + 4 * int'(i);
            w = {b[k], b[k+1], b[k+2], b[k+3]};
            exp_q.push_back({32'(base / 4 + i), w});
            sum = (sum + 64'(w)) % (64'd1 << 32);
        end
`ifdef LOADER_CHECKSUM_EN
        k = 8 + 4 * int'(n);
        c = 64'({b[k], b[k+1], b[k+2], b[k+3]});
        exp_done = (c == sum);
`else
        c = 0;
        exp_done = (c == 0);
`endif
        exp_err = !exp_done;
    endtask

    // Appends the correct trailing sum when the checksum build is used.
    function automatic bq_t with_csum(input bq_t b);
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] s;
        int n;
        s = '0;
        n = int'({b[4], b[5], b[6], b[7]});
        for (int i = 0; i < n && 8 + 4 * i + 3 < b.size(); i++) begin
            s = s + {b[8+4*i], b[9+4*i], b[10+4*i], b[11+4*i]};
        end
        b.push_back(s[31:24]);
        b.push_back(s[23:16]);
        b.push_back(s[15:8]);
        b.push_back(s[7:0]);
`endif
        return b;
    endfunction

    // Write-port monitor and mem_wr_ready driver.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            mem_wr_ready = 1'b0;
            have_prev    = 1'b0;
        end else if (mem_wr_valid) begin
            chk("wr_in_ready_low", 64'(in_ready), 64'd0);
            if (have_prev) begin
                chk("wr_addr_stable", 64'(mem_wr_addr), 64'(prev_a));
                chk("wr_data_stable", 64'(mem_wr_data), 64'(prev_d));
            end
            if (stall_left > 0) begin
                stall_left--;
                mem_wr_ready = 1'b0;
                have_prev    = 1'b1;
                prev_a       = 32'(mem_wr_addr);
                prev_d       = mem_wr_data;
            end else begin
                mem_wr_ready = 1'b1;
                have_prev    = 1'b0;
                n_writes++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr %0h data %0h, required none",
                             mem_wr_addr, mem_wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(mem_wr_addr), 64'(e.a));
                    chk("wr_data", 64'(mem_wr_data), 64'(e.d));
                end
            end
        end else begin
            mem_wr_ready = 1'b1;
            have_prev    = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready_0", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.delete();
        stall_left = 0;
        chk("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
        chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_wr_data", 64'(mem_wr_data), 64'd0);
        chk("rst_hold", 64'(cpu_reset_hold), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_in_ready_1", 64'(in_ready), 64'd1);
    endtask

    // Byte driver; stops once the loader reaches a terminal state.
    task automatic send(input bq_t b, input int gap);
        int t;
        for (int i = 0; i < b.size(); i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            #1;
            t = 0;
            while (!in_ready && !(done || error) && t < 200) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (done || error) break;
            if (t >= 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: byte %0d in_ready stuck 0, required 1", i);
                break;
            end
            @(negedge clk);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_image(input string nm, input bq_t b, input int gap,
                             input int stall);
        int t;
        model(b);
        stall_left = stall;
        n_writes   = 0;
        send(b, gap);
        t = 0;
        while (!(done || error) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: done=%0b error=%0b, required terminal",
                     nm, done, error);
        end
        repeat (2) @(negedge clk);
        #3;
        chk({nm, "_done"}, 64'(done), 64'(exp_done));
        chk({nm, "_error"}, 64'(error), 64'(exp_err));
        chk({nm, "_hold"}, 64'(cpu_reset_hold), 64'(!exp_done));
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({nm, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, required finish");
        $fatal(1);
    end

    initial begin
        bq_t img028, img029, img030a, img030b, img2, imgz, imggap, tmp;

        img028  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        img029  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                    8'hAA, 8'hBB, 8'hCC, 8'hDD};
        img030a = '{8'h00, 8'h0F, 8'hFF, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h02,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        img030b = '{8'h00, 8'h0F, 8'hFF, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h01,
                    8'hDE, 8'hAD, 8'hBE, 8'hEF};
        img2    = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                    8'hCA, 8'hFE, 8'hF0, 8'h0D};
        imgz    = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        imggap  = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01,
                    8'hA5, 8'h5A, 8'hC3, 8'h3C};

        do_reset();

        // Pin the model against hand-computed writes.
        model(img028);
        chk("model_n", 64'(exp_q.size()), 64'd2);
        chk("model_w0", 64'(exp_q[0]), {32'h040, 32'h11223344});
        chk("model_w1", 64'(exp_q[1]), {32'h041, 32'h55667788});
        model(img030b);
        chk("model_top", 64'(exp_q[0]), {32'h3FFFF, 32'hDEADBEEF});
        model(img030a);
        chk("model_range_err", 64'(exp_err), 64'd1);
        exp_q.delete();

        run_image("basic", with_csum(img028), 0, 0);
        chk("basic_nwrites", 64'(n_writes), 64'd2);
        chk("basic_done_lit", 64'(done), 64'd1);

        do_reset();
        run_image("stall", with_csum(img028), 0, 5);
        chk("stall_nwrites", 64'(n_writes), 64'd2);

        do_reset();
        run_image("misalign", with_csum(img029), 0, 0);
        chk("misalign_nwrites", 64'(n_writes), 64'd0);
        chk("misalign_err_lit", 64'(error), 64'd1);

        do_reset();
        run_image("range_over", with_csum(img030a), 0, 0);
        chk("range_over_nwrites", 64'(n_writes), 64'd0);

        do_reset();
        run_image("range_top", with_csum(img030b), 0, 0);
        chk("range_top_nwrites", 64'(n_writes), 64'd1);

        do_reset();
        run_image("empty", with_csum(imgz), 0, 0);
        chk("empty_nwrites", 64'(n_writes), 64'd0);

        do_reset();
        run_image("gaps", with_csum(imggap), 3, 0);
        chk("gaps_nwrites", 64'(n_writes), 64'd1);

        // Reset with a write held pending by mem_wr_ready = 0.
        do_reset();
        model(img028);
        stall_left = 1000;
        tmp = img028[0:11];
        send(tmp, 0);
        @(negedge clk);
        #3;
        chk("pend_valid", 64'(mem_wr_valid), 64'd1);
        chk("pend_addr", 64'(mem_wr_addr), 64'h40);
        do_reset();

        // Reset after the 6th payload byte, then a different image.
        model(img028);
        n_writes = 0;
        tmp = img028[0:13];
        send(tmp, 0);
        repeat (3) @(negedge clk);
        #3;
        chk("mid_nwrites", 64'(n_writes), 64'd1);
        do_reset();
        run_image("reload", with_csum(img2), 0, 0);
        chk("reload_nwrites", 64'(n_writes), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        tmp = with_csum(img028);
        chk("model_csum", 64'({tmp[16], tmp[17], tmp[18], tmp[19]}),
            64'h6688AACC);
        do_reset();
        tmp = img028;
        tmp.push_back(8'h66);
        tmp.push_back(8'h88);
        tmp.push_back(8'hAA);
        tmp.push_back(8'hCC);
        run_image("csum_ok", tmp, 0, 0);
        chk("csum_ok_lit", 64'(done), 64'd1);
        do_reset();
        tmp = img028;
        repeat (4) tmp.push_back(8'h00);
        run_image("csum_bad", tmp, 0, 0);
        chk("csum_bad_lit", 64'(error), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_image_loader.md
MEM_IMAGE_LOADER -- requirements
Module: mem_image_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, giving the memory word-address width.
REQ-002 The block SHALL have port clk, input, 1 bit, the sole clock.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have ports in_valid, input, 1; in_data, input, 8; in_ready, output, 1: the byte stream from the host or serial source.
REQ-005 The block SHALL have ports mem_wr_valid, output, 1; mem_wr_addr, output, ADDR_W; mem_wr_data, output, 32; mem_wr_ready, input, 1: the word-write port into CPU memory.
REQ-006 The block SHALL have port cpu_reset_hold, output, 1: holds the CPU in reset until the load completes.
REQ-007 The block SHALL have ports done, output, 1, and error, output, 1: sticky completion and failure flags.

Function
REQ-008 The image format SHALL be: 4-byte big-endian base byte address, then 4-byte big-endian word count N, then N payload words of 4 big-endian bytes each.
REQ-009 A byte SHALL transfer only on a clock edge where in_valid and in_ready are both 1.
REQ-010 The states SHALL be HDR_ADDR, HDR_LEN, PAYLOAD, WRITE, CSUM, DONE and ERROR; reset SHALL enter HDR_ADDR.
REQ-011 HDR_ADDR SHALL go to HDR_LEN after its 4th byte; HDR_LEN SHALL go to PAYLOAD after its 4th byte.
REQ-012 Leaving HDR_LEN SHALL go to ERROR if base[1:0] != 0, or if (base>>2)+N > 2^ADDR_W, with the sum computed 33 bits wide.
REQ-013 Leaving HDR_LEN with N == 0 SHALL bypass PAYLOAD and go to CSUM when configured, otherwise to DONE.
REQ-014 In PAYLOAD, the 4th accepted byte of a word SHALL move the state to WRITE, with mem_wr_valid = 1 on the next cycle.
REQ-015 mem_wr_addr SHALL start at base>>2 and increment by 1 after each accepted write; in-range checking guarantees it never wraps.
REQ-016 In WRITE, mem_wr_valid, mem_wr_addr and mem_wr_data SHALL hold stable until mem_wr_ready = 1.
REQ-017 in_ready SHALL be 0 in WRITE, DONE and ERROR, and 1 in every other state.
REQ-018 After the Nth write is accepted, the block SHALL go to CSUM when configured, otherwise to DONE; after any earlier write it SHALL return to PAYLOAD.
REQ-019 DONE SHALL drive done = 1 and cpu_reset_hold = 0; ERROR SHALL drive error = 1 and cpu_reset_hold = 1; both states SHALL be terminal until reset.
REQ-020 A stalled in_valid mid-word SHALL hold the partial word indefinitely with no timeout.

Reset
REQ-021 On reset: in_ready = 0 that cycle and 1 from the next; mem_wr_valid = 0; mem_wr_addr = 0; mem_wr_data = 0; cpu_reset_hold = 1; done = 0; error = 0; byte counter and checksum accumulator = 0.
REQ-022 Reset asserted mid-load, including with a write pending, SHALL abandon the write, drop mem_wr_valid on the following cycle, and restart at HDR_ADDR.

Configuration
REQ-023 With macro LOADER_CHECKSUM_EN defined, the block SHALL accumulate a modulo-2^32 sum of the payload words and then read a 4-byte big-endian checksum in CSUM.
REQ-024 With LOADER_CHECKSUM_EN defined, a match in CSUM SHALL go to DONE and a mismatch SHALL go to ERROR.
REQ-025 Without LOADER_CHECKSUM_EN, the CSUM state and the accumulator SHALL be absent.

Structure
REQ-026 A shared package loader_pkg SHALL hold the state enum, the header length constant (4 bytes per field) and the checksum width constant.
REQ-027 Byte-to-word assembly SHALL be one sub-module, be_word_assembler, which takes 8-bit valid data plus a clear input and produces a 32-bit word with a word_valid pulse.

Verification
REQ-028 Stream 00 00 01 00, 00 00 00 02, 11 22 33 44, 55 66 77 88 with mem_wr_ready = 1 -> writes [0x040] = 0x11223344 and [0x041] = 0x55667788, then done = 1 and cpu_reset_hold = 0.
REQ-029 Header base 0x00000102 -> error = 1, no write issued, in_ready = 0.
REQ-030 ADDR_W = 18, base 0x000FFFFC, N = 2 -> error; base 0x000FFFFC, N = 1 -> one write to 0x3FFFF, then done.
REQ-031 mem_wr_ready held at 0 for 5 cycles during the first write -> address and data stable throughout, in_ready = 0, no bytes lost.
REQ-032 Reset pulsed after the 6th payload byte, then a full image sent -> only the second image's words are written, and done = 1.
REQ-033 With LOADER_CHECKSUM_EN, the REQ-028 image plus checksum 66 88 AA CC -> done; checksum 00 00 00 00 -> error.
